// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Optional macro HAZARD_FORWARDING_EN: only load-use hazards stall.
module pipeline_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int MAX_WAIT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic              id_two_src,
   input  logic [REG_AW-1:0] exe_dest,
   input  logic              exe_wb_en,
   input  logic              exe_mem_read,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_wb_en,
   input  logic              branch_taken,
   input  logic              mem_access,
   input  logic              mem_ready,
   output logic              pc_freeze,
   output logic              ifid_freeze,
   output logic              ifid_flush,
   output logic              idexe_bubble,
   output logic              back_freeze,
   output logic              memwb_bubble,
   output logic              mem_timeout,
   output logic [15:0]       stall_count
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [8:0] MAX_W9 = 9'(MAX_WAIT);

   state_t      state;
   state_t      state_next;
   logic [7:0]  wait_cnt;
   logic [8:0]  wait_inc;
   logic        src1_used;
   logic        src2_used;
   logic        exe_hit;
   logic        hazard;

   assign src1_used = (id_src1 != '0);
   assign src2_used = id_two_src && (id_src2 != '0);
   assign exe_hit   = (src1_used && (id_src1 == exe_dest))
                   || (src2_used && (id_src2 == exe_dest));
   assign wait_inc  = {1'b0, wait_cnt} + 9'd1;

`ifdef HAZARD_FORWARDING_EN
   // Forwarding covers ALU results; only a load in EXE cannot be bypassed.
   logic unused_mem;
   assign unused_mem = ^{mem_dest, mem_wb_en};
   assign hazard     = exe_mem_read && exe_wb_en && exe_hit;
`else
   // No bypass network: any pending writer in EXE or MEM blocks ID.
   logic mem_hit;
   logic unused_exe;
   assign unused_exe = exe_mem_read;
   assign mem_hit    = (src1_used && (id_src1 == mem_dest))
                    || (src2_used && (id_src2 == mem_dest));
   assign hazard     = (exe_wb_en && exe_hit) || (mem_wb_en && mem_hit);
`endif

   // Next-state and control decode; reset forces every control low.
   always_comb begin
      state_next   = state;
      pc_freeze    = 1'b0;
      ifid_freeze  = 1'b0;
      ifid_flush   = 1'b0;
      idexe_bubble = 1'b0;
      back_freeze  = 1'b0;
      memwb_bubble = 1'b0;
      if (reset) begin
         state_next = RUN;
      end else begin
         unique case (state)
            RUN: begin
               if (mem_access && !mem_ready) begin
                  // EXE is frozen too, so a pending branch re-presents later.
                  pc_freeze    = 1'b1;
                  ifid_freeze  = 1'b1;
                  back_freeze  = 1'b1;
                  memwb_bubble = 1'b1;
                  state_next   = MEM_WAIT;
               end else if (branch_taken) begin
                  ifid_flush   = 1'b1;
                  idexe_bubble = 1'b1;
               end else if (hazard) begin
                  pc_freeze    = 1'b1;
                  ifid_freeze  = 1'b1;
                  idexe_bubble = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (!mem_ready) begin
                  pc_freeze    = 1'b1;
                  ifid_freeze  = 1'b1;
                  back_freeze  = 1'b1;
                  memwb_bubble = 1'b1;
               end else begin
                  state_next = RUN;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state <= RUN;
      else       state <= state_next;
   end

   // Wait counter and sticky timeout; counter is held clear while running.
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if (state == RUN) begin
         wait_cnt <= '0;
      end else begin
         if (wait_cnt != 8'hFF) wait_cnt <= wait_inc[7:0];
         if (wait_inc >= MAX_W9) mem_timeout <= 1'b1;
      end
   end

   // Saturating count of cycles with the PC held.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_count <= '0;
      end else if (pc_freeze && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MAX_WAIT = 3).
module tb_pipeline_hazard_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
   logic       id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
   logic       branch_taken, mem_access, mem_ready;
   logic       pc_freeze, ifid_freeze, ifid_flush, idexe_bubble;
   logic       back_freeze, memwb_bubble, mem_timeout;
   logic [15:0] stall_count;

   typedef struct {
      string       name;
      logic [5:0]  ctrl;
      logic [15:0] cnt;
      logic        tmo;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   exp_cnt  = 0;
   logic exp_tmo  = 1'b0;

`ifdef HAZARD_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // ctrl = {pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, back_freeze, memwb_bubble}
   localparam logic [5:0] NONE  = 6'b000000;
   localparam logic [5:0] STALL = 6'b110100;
   localparam logic [5:0] FLUSH = 6'b001100;
   localparam logic [5:0] MWAIT = 6'b110011;

   pipeline_hazard_ctrl #(.REG_AW(5), .MAX_WAIT(3)) dut (
      .clock        (clock),
      .reset        (reset),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_two_src   (id_two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_read (exe_mem_read),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .branch_taken (branch_taken),
      .mem_access   (mem_access),
      .mem_ready    (mem_ready),
      .pc_freeze    (pc_freeze),
      .ifid_freeze  (ifid_freeze),
      .ifid_flush   (ifid_flush),
      .idexe_bubble (idexe_bubble),
      .back_freeze  (back_freeze),
      .memwb_bubble (memwb_bubble),
      .mem_timeout  (mem_timeout),
      .stall_count  (stall_count)
   );

   always #5 clock = ~clock;

   // Monitor: compare mid-cycle, away from the rising edge.
   always @(negedge clock) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [5:0] act;
         e   = sb.pop_front();
         act = {pc_freeze, ifid_freeze, ifid_flush,
                idexe_bubble, back_freeze, memwb_bubble};
         checks++;
         if (act !== e.ctrl) begin
            failures++;
            $display("FAIL %s ctrl got=%b exp=%b", e.name, act, e.ctrl);
         end
         checks++;
         if (stall_count !== e.cnt) begin
            failures++;
            $display("FAIL %s stall_count got=%0d exp=%0d",
                     e.name, stall_count, e.cnt);
         end
         checks++;
         if (mem_timeout !== e.tmo) begin
            failures++;
            $display("FAIL %s mem_timeout got=%b exp=%b",
                     e.name, mem_timeout, e.tmo);
         end
      end
   end

   task automatic clear_in();
      id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
      exe_dest = '0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
      mem_dest = '0; mem_wb_en = 1'b0;
      branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
   endtask

   // Inputs are already applied; push the expectation for this cycle.
   task automatic step(input string name, input logic [5:0] ctrl);
      exp_t e;
      e.name = name;
      e.ctrl = ctrl;
      e.cnt  = 16'(exp_cnt);
      e.tmo  = exp_tmo;
      sb.push_back(e);
      if (ctrl[5] && exp_cnt < 16'hFFFF) exp_cnt++;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input string name);
      reset = 1'b1;
      step(name, NONE);
      exp_cnt = 0;
      exp_tmo = 1'b0;
      reset   = 1'b0;
   endtask

   initial begin
      clear_in();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      step("reset_state", NONE);

      // Load-use: one stall cycle, then hazard gone.
      id_src1 = 5'd3; exe_dest = 5'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
      step("load_use", STALL);
      exe_dest = 5'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
      step("load_use_clear", NONE);

      // ALU dependency through MEM on src2.
      clear_in();
      id_src2 = 5'd7; id_two_src = 1'b1; mem_dest = 5'd7; mem_wb_en = 1'b1;
      step("alu_mem_src2", FWD ? NONE : STALL);
      id_two_src = 1'b0;
      step("alu_src2_unused", NONE);

      // ALU dependency in EXE on src1 (not a load).
      clear_in();
      id_src1 = 5'd5; exe_dest = 5'd5; exe_wb_en = 1'b1;
      step("alu_exe_src1", FWD ? NONE : STALL);

      // Register zero never matches.
      clear_in();
      exe_wb_en = 1'b1; exe_mem_read = 1'b1;
      step("src_zero", NONE);

      // Memory wait of 4 not-ready cycles.
      clear_in();
      mem_access = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step("mem_wait", MWAIT);
         if (i == 3) exp_tmo = 1'b1;
      end
      mem_ready = 1'b1;
      step("mem_ready", NONE);
      clear_in();
      branch_taken = 1'b1;
      step("wait_back_run", FLUSH);

      do_reset("reset_ctrl_low");

      // Branch ignored while waiting; flush once back in RUN.
      clear_in();
      branch_taken = 1'b1; mem_access = 1'b1;
      step("branch_in_wait0", MWAIT);
      step("branch_in_wait1", MWAIT);
      mem_ready = 1'b1;
      step("branch_ready", NONE);
      mem_access = 1'b0; mem_ready = 1'b0;
      step("branch_after_wait", FLUSH);
      id_src1 = 5'd3; exe_dest = 5'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
      step("branch_over_hazard", FLUSH);

      // Ready on the first access cycle: no freeze.
      clear_in();
      mem_access = 1'b1; mem_ready = 1'b1;
      step("ready_first", NONE);

      // Timeout with ready stuck low, then reset mid-wait.
      mem_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step("timeout_wait", MWAIT);
         if (i == 3) exp_tmo = 1'b1;
      end
      do_reset("reset_mid_wait");
      step("after_reset", MWAIT);
      do_reset("reset_again");
      mem_ready = 1'b1; branch_taken = 1'b1;
      step("reset_to_run", FLUSH);

      // Saturation: load-use held for 70000 cycles.
      clear_in();
      id_src1 = 5'd9; exe_dest = 5'd9; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
      repeat (70000) @(posedge clock);
      #1;
      exp_cnt = (exp_cnt + 70000 > 65535) ? 65535 : exp_cnt + 70000;
      step("saturate", STALL);
      step("saturate_hold", STALL);

      clear_in();
      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clock);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
